mux8_serializer: RTL and testbench
==================================

Name: mux8_serializer

Overview:
- Parallel-in / serial-out stage built around the existing 8:1 mux (mux8).
- Accepts an 8-bit word over a valid/ready handshake and holds it in a register.
- Drives the mux select from an internal 3-bit counter and presents one bit per accepted serial beat.
- Sits between the word-producing datapath and any single-bit consumer (line driver, LED, bit-level checker).

Parameters:
- MSB_FIRST, 1, 1: bit 7 is sent first (data[7] on mux input D0); 0: bit 0 is sent first (data[0] on D0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  parallel word to serialise.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- ser_bit  output  1  current serial bit (mux8 Y).
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  consumer accepts ser_bit this cycle.
- ser_last  output  1  ser_bit is the 8th bit of the word.
- sel  output  3  current mux select (debug / observability).
- busy  output  1  a word is loaded and not fully sent.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising clk edge.
- Reset:
  - State goes to IDLE and the sel counter to 0.
  - The word register clears to 0.
  - Outputs after the reset edge: ser_valid=0, ser_last=0, busy=0, in_ready=1, sel=0.
  - ser_bit = mux output of the cleared register = 0.
- States:
  - IDLE: in_ready=1, ser_valid=0. On in_valid&&in_ready, latch in_data, sel<=0, go to SHIFT.
  - SHIFT: ser_valid=1, busy=1.
    - Beat fires when ser_valid&&ser_ready.
    - On a beat with sel<7: sel<=sel+1.
    - On a beat with sel==7: sel<=0. If in_valid, latch the new word and stay in SHIFT; otherwise go to IDLE.
- Ready and back-to-back streaming:
  - in_ready = (state==IDLE) || (state==SHIFT && sel==7 && ser_ready).
  - This gives gap-free streaming between consecutive words.
- Mux mapping:
  - MSB_FIRST=1: D0..D7 = data[7]..data[0].
  - MSB_FIRST=0: D0..D7 = data[0]..data[7].
  - ser_bit = Y of mux8 with the 3-bit sel; purely combinational from the registers, no added latency.
- ser_last = (state==SHIFT && sel==7).
- Latency: word accepted at edge N; first bit valid in the cycle after edge N. 8 beats per word; 8 cycles minimum with ser_ready held high.
- Backpressure: while ser_ready=0, sel, the word register and ser_bit hold stable; ser_valid stays 1.
- Wrap-around: sel wraps 7->0 only on a beat. sel never changes in IDLE.
- Simultaneous events: in_valid while in SHIFT with sel<7 is ignored (in_ready=0); the source must hold in_data.
- Reset mid-word: the partially sent word is discarded with no ser_last. The first word after reset starts at sel=0.
- in_data changing while in_ready=0 has no effect on ser_bit.

Decomposition:
- Package mux8_serializer_pkg:
  - state_t enum {IDLE, SHIFT}
  - WORD_W=8, SEL_W=3, LAST_SEL=3'd7
- Sub-module: the existing mux8, instanced once with the 8 reordered register bits, sel and Y.
- All sequencing lives in mux8_serializer; no further split.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream -> next cycle ser_valid=0, busy=0, in_ready=1, sel=0, ser_bit=0.
- MSB_FIRST=1, in_data=8'b1010_1010, ser_ready=1 constant -> ser_bit sequence 1,0,1,0,1,0,1,0 over 8 consecutive cycles; sel 0..7; ser_last only on the 8th; IDLE after.
- MSB_FIRST=0, in_data=8'b1100_0001 -> sequence 1,0,0,0,0,0,1,1.
- Backpressure: in_data=8'hF0, drop ser_ready for 3 cycles at sel=2 -> sel stays 2, ser_bit stays 1, ser_valid=1; resumes and the word completes in 11 cycles total.
- Back-to-back: 8'hA5 then 8'h3C with in_valid held -> in_ready pulses only at sel==7; 16 bits 10100101_00111100 with no idle cycle; ser_last at beats 8 and 16.
- Ignored load: pulse in_valid with 8'hFF at sel=3 of word 8'h00 -> output stays all zeros; 8'hFF is not captured.

Source files
------------

// File: rtl/mux8_serializer_pkg.sv
// Shared types and constants for the mux8-based parallel-in / serial-out stage.
package mux8_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned WORD_W   = 8;
    localparam int unsigned SEL_W    = 3;
    localparam logic [2:0]  LAST_SEL = 3'd7;

endpackage

// File: rtl/mux8.sv
// Existing 8:1 single-bit multiplexer: y = d[sel].
module mux8 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/mux8_serializer.sv
// Accepts an 8-bit word on a valid/ready handshake and streams it out one bit
// per beat through mux8, driving the select from an internal counter.
module mux8_serializer
    import mux8_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    state_t            state;
    state_t            state_n;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_rev;
    logic [WORD_W-1:0] mux_d;
    logic              load;
    logic              beat;
    logic              at_last;

    assign at_last = (sel == LAST_SEL);
    assign load    = in_valid && in_ready;
    assign beat    = (state == SHIFT) && ser_ready;

    // Bit-reversed word puts data[7] on D0 so sel=0 emits the MSB.
    assign word_rev = {<<{word}};
    assign mux_d    = MSB_FIRST ? word_rev : word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                word <= in_data;
                sel  <= '0;
            end else if (beat) begin
                sel <= at_last ? '0 : sel + 3'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = SHIFT;
            SHIFT:   if (beat && at_last) state_n = in_valid ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        ser_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_last  = at_last;
                in_ready  = at_last && ser_ready;
            end
            default: ;
        endcase
    end

    mux8 u_mux8 (
        .d   (mux_d),
        .sel (sel),
        .y   (ser_bit)
    );

endmodule

// File: tb/tb_mux8_serializer.sv
// Checks both bit orders of mux8_serializer against a word/bit-index model,
// with directed vectors and a randomized stream.
module tb_mux8_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic       m_in_ready, m_ser_bit, m_ser_valid, m_ser_last, m_busy;
    logic [2:0] m_sel;
    logic       l_in_ready, l_ser_bit, l_ser_valid, l_ser_last, l_busy;
    logic [2:0] l_sel;

    int checks;
    int errors;

    // reference model: current word, index of the bit on the line, active flag
    logic [7:0] md_word;
    int         md_idx;
    bit         md_active;

    typedef struct {
        logic [7:0] word;
        logic [7:0] msb_seq;  // expected MSB_FIRST=1 stream, first bit leftmost
        logic [7:0] lsb_seq;  // expected MSB_FIRST=0 stream, first bit leftmost
    } vec_t;

    vec_t vecs[5];

    mux8_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .ser_bit   (m_ser_bit),
        .ser_valid (m_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (m_ser_last),
        .sel       (m_sel),
        .busy      (m_busy)
    );

    mux8_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .ser_bit   (l_ser_bit),
        .ser_valid (l_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (l_ser_last),
        .sel       (l_sel),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_in_ready();
        return !md_active || (md_idx == 7 && ser_ready);
    endfunction

    function automatic bit exp_bit(input bit msb_first);
        logic [7:0] sh;
        sh = msb_first ? (md_word >> (7 - md_idx)) : (md_word >> md_idx);
        return sh[0];
    endfunction

    task automatic model_compare();
        chk("ser_valid_m", m_ser_valid, md_active);
        chk("ser_valid_l", l_ser_valid, md_active);
        chk("busy_m",      m_busy,      md_active);
        chk("busy_l",      l_busy,      md_active);
        chk("in_ready_m",  m_in_ready,  exp_in_ready());
        chk("in_ready_l",  l_in_ready,  exp_in_ready());
        chk("sel_m",       m_sel,       md_idx);
        chk("sel_l",       l_sel,       md_idx);
        chk("ser_last_m",  m_ser_last,  md_active && md_idx == 7);
        chk("ser_last_l",  l_ser_last,  md_active && md_idx == 7);
        chk("ser_bit_m",   m_ser_bit,   exp_bit(1'b1));
        chk("ser_bit_l",   l_ser_bit,   exp_bit(1'b0));
    endtask

    task automatic model_update();
        bit load, beat;
        load = in_valid && exp_in_ready();
        beat = md_active && ser_ready;
        if (reset) begin
            md_word = '0; md_idx = 0; md_active = 0;
        end else begin
            if (beat) begin
                if (md_idx == 7) begin
                    md_idx = 0; md_active = 0;
                end else begin
                    md_idx++;
                end
            end
            if (load) begin
                md_word = in_data; md_idx = 0; md_active = 1;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_compare();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0;
        ser_ready = 1;
        while (md_active && n < 20) begin
            at_neg(); at_pos(); n++;
        end
        chk("drain_timeout", n < 20, 1);
    endtask

    initial begin
        logic [15:0] got16;
        logic [15:0] last16;
        int          cyc;
        bit          done;

        vecs[0] = '{8'hAA, 8'b1010_1010, 8'b0101_0101};
        vecs[1] = '{8'hC1, 8'b1100_0001, 8'b1000_0011};
        vecs[2] = '{8'hF0, 8'b1111_0000, 8'b0000_1111};
        vecs[3] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
        vecs[4] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};

        checks = 0; errors = 0;
        md_word = '0; md_idx = 0; md_active = 0;
        reset = 1; in_valid = 0; in_data = '0; ser_ready = 1;
        at_pos(); at_pos();
        reset = 0;
        at_neg();
        chk("rst_ser_valid", m_ser_valid, 0);
        chk("rst_in_ready",  m_in_ready,  1);
        chk("rst_sel",       m_sel,       0);
        chk("rst_ser_bit",   m_ser_bit,   0);
        at_pos();

        // directed words, ser_ready held high
        foreach (vecs[v]) begin
            in_data = vecs[v].word; in_valid = 1; ser_ready = 1;
            at_neg();
            chk("vec_idle_ready", m_in_ready, 1);
            at_pos();
            in_valid = 0; in_data = ~vecs[v].word;
            for (int k = 0; k < 8; k++) begin
                at_neg();
                chk("vec_msb_bit", m_ser_bit, vecs[v].msb_seq[7-k]);
                chk("vec_lsb_bit", l_ser_bit, vecs[v].lsb_seq[7-k]);
                chk("vec_sel",     m_sel, k);
                chk("vec_last",    m_ser_last, k == 7);
                at_pos();
            end
            at_neg();
            chk("vec_back_idle", m_ser_valid, 0);
            at_pos();
        end

        // backpressure at sel=2: 3 stalled cycles, 11 cycles total
        in_data = 8'hF0; in_valid = 1; ser_ready = 1;
        at_neg(); at_pos();
        in_valid = 0;
        cyc = 0; done = 0;
        while (!done && cyc < 30) begin
            ser_ready = !(cyc >= 2 && cyc < 5);
            at_neg();
            if (!ser_ready) begin
                chk("bp_sel",   m_sel, 2);
                chk("bp_bit",   m_ser_bit, 1);
                chk("bp_valid", m_ser_valid, 1);
            end
            done = m_ser_last && ser_ready;
            at_pos();
            cyc++;
        end
        chk("bp_cycles", cyc, 11);
        drain();

        // back-to-back A5 then 3C with in_valid held
        in_data = 8'hA5; in_valid = 1; ser_ready = 1;
        at_neg(); at_pos();
        in_data = 8'h3C;
        got16 = '0; last16 = '0;
        for (int b = 0; b < 16; b++) begin
            at_neg();
            got16[15-b]  = m_ser_bit;
            last16[15-b] = m_ser_last;
            chk("b2b_valid", m_ser_valid, 1);
            if (b < 8) chk("b2b_in_ready", m_in_ready, b == 7);
            at_pos();
            if (b == 7) in_valid = 0;
        end
        chk("b2b_bits", got16, 16'b1010_0101_0011_1100);
        chk("b2b_last", last16, 16'h0101);
        at_neg();
        chk("b2b_idle", m_ser_valid, 0);
        at_pos();

        // ignored load of FF while word 00 is at sel=3
        in_data = 8'h00; in_valid = 1;
        at_neg(); at_pos();
        in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k == 3); in_data = (k == 3) ? 8'hFF : 8'h00;
            at_neg();
            chk("ign_ready", m_in_ready, k == 7);
            chk("ign_bit",   m_ser_bit, 0);
            at_pos();
        end
        in_valid = 0;
        at_neg();
        chk("ign_idle_bit", m_ser_bit, 0);
        chk("ign_idle_lsb", l_ser_bit, 0);
        at_pos();

        // reset held 2 cycles mid-word
        in_data = 8'hFF; in_valid = 1;
        at_neg(); at_pos();
        in_valid = 0;
        at_neg(); at_pos(); at_neg(); at_pos();
        reset = 1;
        at_pos(); at_pos();
        reset = 0;
        at_neg();
        chk("mid_rst_valid", m_ser_valid, 0);
        chk("mid_rst_busy",  m_busy, 0);
        chk("mid_rst_ready", m_in_ready, 1);
        chk("mid_rst_sel",   m_sel, 0);
        chk("mid_rst_bit",   m_ser_bit, 0);
        at_pos();

        // randomized stream against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 79) == 0);
            at_neg(); at_pos();
        end
        reset = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
